alu_md: RTL

Parametrised successor to the single-cycle pipeline ALU, instantiated in the EX stage. It executes the existing logic/arithmetic/shift ops in one registered cycle. It adds a multi-cycle multiply/divide unit with architectural HI/LO registers, plus MFHI/MFLO/MTHI/MTLO. A valid/ready handshake lets the hazard unit stall the pipeline while a multiply or divide is in flight.

---
 rtl/alu_md_pkg.sv | 37 +++
 rtl/alu_md_if.sv | 20 ++
 rtl/alu_md_md_unit.sv | 106 ++++++++++
 rtl/alu_md.sv | 98 +++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Shared ALU op codes and multiply/divide state encoding for alu_md.
package alu_md_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLT   = 5'd2,
        OP_SLTU  = 5'd3,
        OP_XOR   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_NOR   = 5'd7,
        OP_LUI   = 5'd8,
        OP_SLL   = 5'd9,
        OP_SRL   = 5'd10,
        OP_SRA   = 5'd11,
        OP_MULT  = 5'd12,
        OP_MULTU = 5'd13,
        OP_DIV   = 5'd14,
        OP_DIVU  = 5'd15,
        OP_MFHI  = 5'd16,
        OP_MFLO  = 5'd17,
        OP_MTHI  = 5'd18,
        OP_MTLO  = 5'd19
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_md_op(alu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// EX-stage ALU request/response bundle; the pipeline is master, alu_md is slave.
interface alu_md_if #(parameter int WIDTH = 32);
    import alu_md_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output in_valid, op, a, b, flush,
                    input  in_ready, out_valid, out_result, hi, lo);
    modport slave  (input  in_valid, op, a, b, flush,
                    output in_ready, out_valid, out_result, hi, lo);
endinterface

// File: rtl/alu_md_md_unit.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
// ALU_MD_FAST_MUL_EN: multiplies use a single-cycle '*' and skip CALC.
module md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_n_o,
    output logic [WIDTH-1:0] lo_n_o
);
    localparam int DW = 2 * WIDTH;

    md_state_e        state_q;
    logic [SHW-1:0]   cnt_q;
    logic [DW-1:0]    acc_q;   // multiply: {hi,lo} product; divide: {remainder, quotient}
    logic [WIDTH-1:0] dvs_q;
    logic             is_div_q, a_neg_q, b_neg_q, div0_q;

    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_w, trial;
    logic [DW-1:0]    mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0] quo, rem;

    always_comb begin
        sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
        mag_a = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

        add_w   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_nxt = {add_w, acc_q[WIDTH-1:1]};

        // A borrow out of the top bit means the partial remainder is below the divisor.
        trial   = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dvs_q};
        div_nxt = trial[WIDTH] ? {acc_q[DW-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[DW-1:WIDTH];
        if (is_div_q) begin
            lo_n_o = div0_q ? '1 : ((a_neg_q ^ b_neg_q) ? -quo : quo);
            hi_n_o = a_neg_q ? -rem : rem;
        end else begin
            lo_n_o = prod[WIDTH-1:0];
            hi_n_o = prod[DW-1:WIDTH];
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    is_div_q <= (op_i == OP_DIV) || (op_i == OP_DIVU);
                    a_neg_q  <= sgn && a_i[WIDTH-1];
                    b_neg_q  <= sgn && b_i[WIDTH-1];
                    div0_q   <= (b_i == '0);
                    dvs_q    <= mag_b;
                    acc_q    <= {{WIDTH{1'b0}}, mag_a};
                    cnt_q    <= '0;
                    state_q  <= ST_CALC;
`ifdef ALU_MD_FAST_MUL_EN
                    if ((op_i == OP_MULT) || (op_i == OP_MULTU)) begin
                        acc_q   <= DW'(mag_a) * DW'(mag_b);
                        state_q <= ST_DONE;
                    end
`endif
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= is_div_q ? div_nxt : mul_nxt;
                        cnt_q <= cnt_q + SHW'(1);
                        if (cnt_q == SHW'(WIDTH - 1))
                            state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle logic/arith/shift ops, HI/LO moves, and a
// multi-cycle multiply/divide via md_unit (see ALU_MD_FAST_MUL_EN there).
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_md_if.slave  bus
);
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d, simple_res;
    logic             vld_q, vld_d;
    logic             accept, md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [SHW-1:0]   shamt;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign shamt  = bus.a[SHW-1:0];

    md_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && is_md_op(bus.op)),
        .flush_i (bus.flush),
        .op_i    (bus.op),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .hi_n_o  (md_hi),
        .lo_n_o  (md_lo)
    );

    always_comb begin
        simple_res = '0;
        case (bus.op)
            OP_ADD:  simple_res = bus.a + bus.b;
            OP_SUB:  simple_res = bus.a - bus.b;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_XOR:  simple_res = bus.a ^ bus.b;
            OP_AND:  simple_res = bus.a & bus.b;
            OP_OR:   simple_res = bus.a | bus.b;
            OP_NOR:  simple_res = ~(bus.a | bus.b);
            OP_LUI:  simple_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL:  simple_res = bus.b << shamt;
            OP_SRL:  simple_res = bus.b >> shamt;
            OP_SRA:  simple_res = $signed(bus.b) >>> shamt;
            OP_MFHI: simple_res = hi_q;
            OP_MFLO: simple_res = lo_q;
            OP_MTHI: simple_res = bus.a;
            OP_MTLO: simple_res = bus.a;
            default: simple_res = '0;
        endcase
    end

    // md_done and a simple accept are exclusive: accept needs the unit idle.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        res_d = res_q;
        vld_d = 1'b0;
        if (md_done && !bus.flush) begin
            hi_d  = md_hi;
            lo_d  = md_lo;
            res_d = md_lo;
            vld_d = 1'b1;
        end else if (accept && !is_md_op(bus.op)) begin
            res_d = simple_res;
            vld_d = 1'b1;
            if (bus.op == OP_MTHI) hi_d = bus.a;
            if (bus.op == OP_MTLO) lo_d = bus.a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign bus.in_ready   = !md_busy;
    assign bus.out_valid  = vld_q;
    assign bus.out_result = res_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;

endmodule
